instruction_decode_hz: RTL

- Parametrised ID stage of the 5-stage MIPS pipeline: control decode, register file, sign extension, branch-target adder and the ID/EX pipeline register.
- New relative to the current ID stage:
  - synchronous reset;
  - register file with write-through bypass and hardwired r0;
  - built-in load-use hazard detection with stall output and bubble insertion;
  - branch flush input.
- Sits between the IF/ID register and the EX stage. stall_out feeds the PC and the IF/ID hold enables.

---
 rtl/pipeline_pkg.sv | 63 ++++++
 rtl/registers_bypass.sv | 48 ++++
 rtl/instruction_decode_hz.sv | 116 +++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared opcodes, ALUOp encodings and control bundle for the ID stage
package pipeline_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Unknown opcodes fall through as a NOP bundle.
    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
        ctrl_t c;
        c = CTRL_NOP;
        case (opcode)
            OP_RTYPE: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = ALUOP_RTYPE;
            end
            OP_LW: begin
                c.alu_src    = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
                c.alu_op     = ALUOP_MEM;
            end
            OP_SW: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
                c.alu_op    = ALUOP_MEM;
            end
            OP_BEQ: begin
                c.branch = 1'b1;
                c.alu_op = ALUOP_BEQ;
            end
            OP_ADDI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = ALUOP_MEM;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/registers_bypass.sv
// rtl/registers_bypass.sv - register file with sync reset, hardwired r0 and write-through reads
module registers_bypass #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      i_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0]     i_wr_data,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd_addr_a,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd_addr_b,
    output logic [DATA_WIDTH-1:0]     o_rd_data_a,
    output logic [DATA_WIDTH-1:0]     o_rd_data_b
);

    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic                  w_wr_valid;

    assign w_wr_valid = i_wr_en && (i_wr_addr != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_valid) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // A same-cycle write-back wins over the stored value so ID sees fresh data.
    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [REG_ADDR_WIDTH-1:0] addr);
        if (addr == '0) begin
            return '0;
        end else if (w_wr_valid && (i_wr_addr == addr)) begin
            return i_wr_data;
        end else begin
            return r_regs[addr];
        end
    endfunction

    assign o_rd_data_a = read_port(i_rd_addr_a);
    assign o_rd_data_b = read_port(i_rd_addr_b);

endmodule

// File: rtl/instruction_decode_hz.sv
// rtl/instruction_decode_hz.sv - MIPS ID stage with load-use stall, flush and ID/EX register
module instruction_decode_hz
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int PC_WIDTH       = 11,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [31:0]               instruction,
    input  logic [PC_WIDTH-1:0]       current_pc,
    input  logic [DATA_WIDTH-1:0]     write_back_data,
    input  logic [REG_ADDR_WIDTH-1:0] write_back_address,
    input  logic                      RegWrite,
    input  logic                      flush,
    output logic                      stall_out,
    output logic [PC_WIDTH-1:0]       jump_dest_addr,
    output logic [DATA_WIDTH-1:0]     data_a,
    output logic [DATA_WIDTH-1:0]     data_b,
    output logic [DATA_WIDTH-1:0]     sign_extended,
    output logic [REG_ADDR_WIDTH-1:0] reg_dest_r_type,
    output logic [REG_ADDR_WIDTH-1:0] reg_dest_l_type,
    output logic                      RegDst_out,
    output logic                      ALUSrc_out,
    output logic                      MemToReg_out,
    output logic                      RegWrite_out,
    output logic                      MemRead_out,
    output logic                      MemWrite_out,
    output logic                      Branch_out,
    output logic [1:0]                ALUOp_out
);

    logic [REG_ADDR_WIDTH-1:0] w_rs;
    logic [REG_ADDR_WIDTH-1:0] w_rt;
    logic [REG_ADDR_WIDTH-1:0] w_rd;
    logic [DATA_WIDTH-1:0]     w_read_a;
    logic [DATA_WIDTH-1:0]     w_read_b;
    logic [DATA_WIDTH-1:0]     w_sext;
    logic [PC_WIDTH-1:0]       w_branch_offset;
    logic [PC_WIDTH-1:0]       w_target;
    ctrl_t                     w_ctrl;
    logic                      w_hazard;

    logic [PC_WIDTH-1:0]       r_jump_dest;
    logic [DATA_WIDTH-1:0]     r_data_a;
    logic [DATA_WIDTH-1:0]     r_data_b;
    logic [DATA_WIDTH-1:0]     r_sext;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic [REG_ADDR_WIDTH-1:0] r_rt;
    ctrl_t                     r_ctrl;

    assign w_rs = REG_ADDR_WIDTH'(instruction[25:21]);
    assign w_rt = REG_ADDR_WIDTH'(instruction[20:16]);
    assign w_rd = REG_ADDR_WIDTH'(instruction[15:11]);

    registers_bypass #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_regs (
        .clock       (clock),
        .reset       (reset),
        .i_wr_en     (RegWrite),
        .i_wr_addr   (write_back_address),
        .i_wr_data   (write_back_data),
        .i_rd_addr_a (w_rs),
        .i_rd_addr_b (w_rt),
        .o_rd_data_a (w_read_a),
        .o_rd_data_b (w_read_b)
    );

    assign w_ctrl          = decode_ctrl(instruction[31:26]);
    assign w_sext          = DATA_WIDTH'($signed(instruction[15:0]));
    assign w_branch_offset = PC_WIDTH'({w_sext, 2'b00});
    assign w_target        = current_pc + w_branch_offset;

    // The load in EX writes rt; a consumer in ID must wait one cycle for it.
    assign w_hazard  = r_ctrl.mem_read && (r_rt != '0) && ((r_rt == w_rs) || (r_rt == w_rt));
    assign stall_out = w_hazard && !flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_jump_dest <= '0;
            r_data_a    <= '0;
            r_data_b    <= '0;
            r_sext      <= '0;
            r_rd        <= '0;
            r_rt        <= '0;
            r_ctrl      <= CTRL_NOP;
        end else begin
            r_jump_dest <= w_target;
            r_data_a    <= w_read_a;
            r_data_b    <= w_read_b;
            r_sext      <= w_sext;
            r_rd        <= w_rd;
            r_rt        <= w_rt;
            r_ctrl      <= (flush || w_hazard) ? CTRL_NOP : w_ctrl;
        end
    end

    assign jump_dest_addr  = r_jump_dest;
    assign data_a          = r_data_a;
    assign data_b          = r_data_b;
    assign sign_extended   = r_sext;
    assign reg_dest_r_type = r_rd;
    assign reg_dest_l_type = r_rt;
    assign RegDst_out      = r_ctrl.reg_dst;
    assign ALUSrc_out      = r_ctrl.alu_src;
    assign MemToReg_out    = r_ctrl.mem_to_reg;
    assign RegWrite_out    = r_ctrl.reg_write;
    assign MemRead_out     = r_ctrl.mem_read;
    assign MemWrite_out    = r_ctrl.mem_write;
    assign Branch_out      = r_ctrl.branch;
    assign ALUOp_out       = r_ctrl.alu_op;

endmodule
